cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL use parameter TIMEOUT_CYCLES, default 15, meaning AWAIT cycles allowed before abandoning a processor transaction (legal range 1..15).
REQ-002 SHALL use parameter IDLE_MSG, default 22'h3FFFFF, meaning the all-ones bus-idle word.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port req0_valid, input, 1 bit, processor 0 has a message.
REQ-006 SHALL have port req0_msg, input, 22 bits, processor 0 message: [21:16] op, [15:13] tag, [12] proc id, [11:0] payload.
REQ-007 SHALL have port req0_ready, output, 1 bit, combinational accept for processor 0.
REQ-008 SHALL have ports req1_valid (input, 1), req1_msg (input, 22) and req1_ready (output, 1), the same as REQ-005..007 for processor 1.
REQ-009 SHALL have ports dir_valid (input, 1), dir_msg (input, 22) and dir_ready (output, 1), the same handshake for the directory (L2) emitter.
REQ-010 SHALL have port CDB, output, 22 bits, registered common data bus.
REQ-011 SHALL have port grant, output, 2 bits, registered owner of the current CDB word: 00 none, 01 P0, 10 P1, 11 directory.
REQ-012 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-013 SHALL have port timeout, output, 1 bit, a one-cycle pulse when AWAIT expires.

Function
REQ-014 SHALL implement states IDLE, DRIVE_P (processor word on bus), DRIVE_D (directory word on bus) and AWAIT (waiting for the directory response).
REQ-015 SHALL complete a transfer on a posedge where valid && ready; the accepted message appears on CDB the next cycle for exactly one cycle, then CDB returns to IDLE_MSG.
REQ-016 SHALL have CDB = IDLE_MSG and grant = 00 in every cycle not in DRIVE_P or DRIVE_D.
REQ-017 SHALL, in IDLE, give the directory absolute priority: dir_valid sets dir_ready = 1, both reqN_ready = 0, and the next state is DRIVE_D.
REQ-018 SHALL, in IDLE without dir_valid, grant exactly one valid processor; if both are valid, the grant goes to the processor not named by last pointer lp, and lp is updated to the winner on acceptance.
REQ-019 SHALL move IDLE -> DRIVE_P on processor acceptance, then DRIVE_P -> AWAIT unconditionally after one cycle.
REQ-020 SHALL move DRIVE_D -> IDLE unconditionally after one cycle.
REQ-021 SHALL hold all ready signals at 0 in DRIVE_P and DRIVE_D.
REQ-022 SHALL, in AWAIT, keep reqN_ready = 0 and set dir_ready = dir_valid; on acceptance the next state is DRIVE_D.
REQ-023 SHALL clear the 4-bit AWAIT counter on entry and increment it each AWAIT cycle without acceptance; on the cycle it equals TIMEOUT_CYCLES-1 without dir_valid, the block pulses timeout next cycle and returns to IDLE.
REQ-024 SHALL give precedence to dir_valid when it arrives in the final AWAIT cycle: DRIVE_D is entered and timeout is not asserted.
REQ-025 SHALL accept a processor or directory message equal to IDLE_MSG (handshake completes) and drop it, staying in or returning to IDLE; lp still updates.
REQ-026 SHALL hold requester msg signals stable by requester contract while valid is high; the arbiter samples msg only at the acceptance edge.
REQ-027 SHALL let a requester that deasserts valid before acceptance lose its turn, with no state change.

Reset
REQ-028 SHALL, while reset is high, force state IDLE, CDB = IDLE_MSG, grant = 00, timeout = 0, counter = 0 and lp = P1 (so P0 wins the first tie), regardless of clock.
REQ-029 SHALL let reset asserted in any state, including mid-AWAIT or DRIVE, abandon the transaction without a timeout pulse; ready outputs are 0 during reset.

Verification
REQ-030 SHALL cover: P0 sends 22'h00A000 -> req0_ready = 1; next cycle CDB = 22'h00A000 and grant = 01; then AWAIT with CDB = 22'h3FFFFF.
REQ-031 SHALL cover: P0 and P1 both valid in IDLE after reset -> P0 wins; after AWAIT ends, P1 wins the next tie.
REQ-032 SHALL cover: dir_valid in AWAIT cycle 3 with 22'h04C000 -> next cycle CDB = 22'h04C000, grant = 11, then IDLE with no timeout.
REQ-033 SHALL cover: no directory response for 15 AWAIT cycles -> timeout pulses for 1 cycle, busy falls, and a pending P1 is granted the next cycle.
REQ-034 SHALL cover: dir_valid and req0_valid together in IDLE -> dir_ready = 1 and req0_ready = 0; P0 is served after DRIVE_D.
REQ-035 SHALL cover: reset pulsed during DRIVE_P -> CDB immediately = 22'h3FFFFF, state IDLE and timeout never asserted.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two processors and a directory share one registered
// 22-bit bus. Processor transactions wait in AWAIT for a directory response,
// bounded by a timeout counter.
module cdb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [21:0] IDLE_MSG       = 22'h3FFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [21:0] req0_msg,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [21:0] req1_msg,
    output logic        req1_ready,
    input  logic        dir_valid,
    input  logic [21:0] dir_msg,
    output logic        dir_ready,
    output logic [21:0] CDB,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;
    localparam logic [1:0] GRANT_DIR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_P = 2'd1,
        DRIVE_D = 2'd2,
        AWAIT   = 2'd3
    } state_t;

    state_t             r_state;
    logic [21:0]        r_cdb;
    logic [1:0]         r_grant;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_lp;       // last processor granted: 0 = P0, 1 = P1

    state_t             w_state_nxt;
    logic [21:0]        w_cdb_nxt;
    logic [1:0]         w_grant_nxt;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_lp_nxt;
    logic               w_pick1;
    logic [21:0]        w_pmsg;
    logic               w_req0_ready;
    logic               w_req1_ready;
    logic               w_dir_ready;

    // State and registered bus outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cdb     <= IDLE_MSG;
            r_grant   <= GRANT_NONE;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_lp      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cdb     <= w_cdb_nxt;
            r_grant   <= w_grant_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lp      <= w_lp_nxt;
        end
    end

    // Next-state, handshake and next bus word; a bus word only lives one cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_cdb_nxt     = IDLE_MSG;
        w_grant_nxt   = GRANT_NONE;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_lp_nxt      = r_lp;
        w_req0_ready  = 1'b0;
        w_req1_ready  = 1'b0;
        w_dir_ready   = 1'b0;
        // On a tie P1 wins only if P0 was served last
        w_pick1       = req1_valid && (!req0_valid || !r_lp);
        w_pmsg        = w_pick1 ? req1_msg : req0_msg;

        case (r_state)
            IDLE: begin
                if (dir_valid) begin
                    w_dir_ready = 1'b1;
                    if (dir_msg != IDLE_MSG) begin
                        w_state_nxt = DRIVE_D;
                        w_cdb_nxt   = dir_msg;
                        w_grant_nxt = GRANT_DIR;
                    end
                end else if (req0_valid || req1_valid) begin
                    w_req0_ready = !w_pick1;
                    w_req1_ready = w_pick1;
                    w_lp_nxt     = w_pick1;
                    // An idle-word message is accepted and dropped
                    if (w_pmsg != IDLE_MSG) begin
                        w_state_nxt = DRIVE_P;
                        w_cdb_nxt   = w_pmsg;
                        w_grant_nxt = w_pick1 ? GRANT_P1 : GRANT_P0;
                    end
                end
            end
            DRIVE_P: begin
                w_state_nxt = AWAIT;
                w_cnt_nxt   = '0;
            end
            DRIVE_D: begin
                w_state_nxt = IDLE;
            end
            AWAIT: begin
                w_dir_ready = dir_valid;
                if (dir_valid) begin
                    if (dir_msg != IDLE_MSG) begin
                        w_state_nxt = DRIVE_D;
                        w_cdb_nxt   = dir_msg;
                        w_grant_nxt = GRANT_DIR;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // No handshake may complete while reset is held
        if (reset) begin
            w_req0_ready = 1'b0;
            w_req1_ready = 1'b0;
            w_dir_ready  = 1'b0;
        end
    end

    // Output mapping
    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign dir_ready  = w_dir_ready;
    assign CDB        = r_cdb;
    assign grant      = r_grant;
    assign timeout    = r_timeout;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: priority, round-robin ties, AWAIT response,
// timeout, idle-word drop and reset abort.
module tb_cdb_arbiter;

    localparam logic [21:0] IDLE_W = 22'h3FFFFF;
    localparam logic [21:0] MSG0   = 22'h00A000;
    localparam logic [21:0] MSG1   = 22'h011ABC;
    localparam logic [21:0] DMSGA  = 22'h04C000;
    localparam logic [21:0] DMSGB  = 22'h08D123;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, dir_valid;
    logic [21:0] req0_msg, req1_msg, dir_msg;
    logic        req0_ready, req1_ready, dir_ready;
    logic [21:0] CDB;
    logic [1:0]  grant;
    logic        busy, timeout;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_msg   (req0_msg),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_msg   (req1_msg),
        .req1_ready (req1_ready),
        .dir_valid  (dir_valid),
        .dir_msg    (dir_msg),
        .dir_ready  (dir_ready),
        .CDB        (CDB),
        .grant      (grant),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_msg = MSG0;
        req1_valid = 1'b0; req1_msg = MSG1;
        dir_valid  = 1'b0; dir_msg  = DMSGA;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cdb", 32'(CDB), 32'(IDLE_W));
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);

        // Tie after reset: P0 wins
        reset = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("tie1_req0_ready", 32'(req0_ready), 32'd1);
        chk("tie1_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("dp0_cdb", 32'(CDB), 32'(MSG0));
        chk("dp0_grant", 32'(grant), 32'd1);
        chk("dp0_busy", 32'(busy), 32'd1);
        chk("dp0_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        chk("aw0_cdb", 32'(CDB), 32'(IDLE_W));
        chk("aw0_grant", 32'(grant), 32'd0);

        // 15 silent AWAIT cycles, P1 pending throughout
        for (int i = 0; i < 15; i++) begin
            chk("aw_timeout_low", 32'(timeout), 32'd0);
            chk("aw_busy", 32'(busy), 32'd1);
            chk("aw_req1_ready", 32'(req1_ready), 32'd0);
            tick();
        end
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_cdb", 32'(CDB), 32'(IDLE_W));
        // Second tie: P1 wins
        req0_valid = 1'b1;
        #1;
        chk("tie2_req1_ready", 32'(req1_ready), 32'd1);
        chk("tie2_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        chk("to_one_cycle", 32'(timeout), 32'd0);
        chk("dp1_cdb", 32'(CDB), 32'(MSG1));
        chk("dp1_grant", 32'(grant), 32'd2);

        // Directory answers in AWAIT cycle 3
        tick();
        chk("aw1_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        tick();
        dir_valid = 1'b1; dir_msg = DMSGA;
        #1;
        chk("aw3_dir_ready", 32'(dir_ready), 32'd1);
        chk("aw3_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        dir_valid = 1'b0;
        #1;
        chk("dd_cdb", 32'(CDB), 32'(DMSGA));
        chk("dd_grant", 32'(grant), 32'd3);
        chk("dd_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        chk("dd_idle_busy", 32'(busy), 32'd0);
        chk("dd_idle_cdb", 32'(CDB), 32'(IDLE_W));
        chk("dd_no_timeout", 32'(timeout), 32'd0);
        chk("p0_served_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("dp2_cdb", 32'(CDB), 32'(MSG0));

        // Reset pulse during DRIVE_P aborts immediately
        reset = 1'b1;
        #1;
        chk("rstdp_cdb", 32'(CDB), 32'(IDLE_W));
        chk("rstdp_grant", 32'(grant), 32'd0);
        chk("rstdp_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("rstdp_no_timeout", 32'(timeout), 32'd0);
            chk("rstdp_idle", 32'(busy), 32'd0);
            tick();
        end

        // Directory beats processors in IDLE; then P0 wins the tie (lp reset)
        dir_valid = 1'b1; dir_msg = DMSGB;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("pri_dir_ready", 32'(dir_ready), 32'd1);
        chk("pri_req0_ready", 32'(req0_ready), 32'd0);
        chk("pri_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        dir_valid = 1'b0;
        chk("pri_cdb", 32'(CDB), 32'(DMSGB));
        chk("pri_grant", 32'(grant), 32'd3);
        tick();
        chk("post_dd_req0_ready", 32'(req0_ready), 32'd1);
        chk("post_dd_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("dp3_grant", 32'(grant), 32'd1);
        tick();

        // Directory replies with the idle word: accepted and dropped
        dir_valid = 1'b1; dir_msg = IDLE_W;
        #1;
        chk("drop_dir_ready", 32'(dir_ready), 32'd1);
        tick();
        dir_valid = 1'b0;
        chk("drop_dir_busy", 32'(busy), 32'd0);
        chk("drop_dir_grant", 32'(grant), 32'd0);
        chk("drop_dir_timeout", 32'(timeout), 32'd0);

        // P1 sends the idle word: handshake completes, nothing driven, lp -> P1
        req1_msg = IDLE_W;
        #1;
        chk("drop_p1_ready", 32'(req1_ready), 32'd1);
        tick();
        chk("drop_p1_busy", 32'(busy), 32'd0);
        chk("drop_p1_cdb", 32'(CDB), 32'(IDLE_W));
        chk("drop_p1_grant", 32'(grant), 32'd0);
        req1_msg = MSG1;
        req0_valid = 1'b1;
        #1;
        chk("tie3_req0_ready", 32'(req0_ready), 32'd1);
        chk("tie3_req1_ready", 32'(req1_ready), 32'd0);

        // Requester withdrawing before acceptance changes nothing
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("withdraw_busy", 32'(busy), 32'd0);
        chk("withdraw_grant", 32'(grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
